// File: rtl/a2d_sched_if.sv
// -----------------------------------------------------------------------------
// a2d_sched_if -- bundle between the A2D round-robin scheduler and its
// surroundings (request source, SPI master, result consumers).
//
//   nxt        request to start one conversion (one-cycle pulse)
//   wrt, cmd   SPI transaction start strobe and command word
//   done       SPI transaction complete (one-cycle pulse)
//   rd_data    word received by the SPI master, valid with done
//   lft_ld, rght_ld, steer_pot, batt   latest 12-bit results per channel
//   vld, ch_id result-update pulse and the slot it refers to
//   busy, err  scheduler not idle / sticky timeout flag
//
// Modport master is the scheduler side; modport slave is everything around it.
// -----------------------------------------------------------------------------
interface a2d_sched_if;
   logic        nxt;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic [11:0] steer_pot;
   logic [11:0] batt;
   logic        vld;
   logic [1:0]  ch_id;
   logic        busy;
   logic        err;

   modport master (
      input  nxt, done, rd_data,
      output wrt, cmd, lft_ld, rght_ld, steer_pot, batt, vld, ch_id, busy, err
   );

   modport slave (
      output nxt, done, rd_data,
      input  wrt, cmd, lft_ld, rght_ld, steer_pot, batt, vld, ch_id, busy, err
   );
endinterface

// File: rtl/a2d_sched.sv
// -----------------------------------------------------------------------------
// a2d_sched -- round-robin A2D conversion scheduler.
//
// Each request on nxt runs one conversion on the next slot in the rotation
// (slot0 ch0 left load cell, slot1 ch4 right load cell, slot2 ch5 steer pot,
// slot3 ch6 battery). A conversion is two SPI transactions: a command that
// selects the channel, an idle gap of GAP_CYCLES, then a read that returns
// the converted value. A transaction that does not complete within TIMEOUT
// cycles abandons the conversion, sets the sticky err flag and moves on.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   a2d_sched_if.master (request, SPI handshake, results, status)
// -----------------------------------------------------------------------------
module a2d_sched #(
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic        clk,
   input  logic        rst,
   a2d_sched_if.master bus
);

   // Counter covers both the gap length and the full timeout without wrapping.
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAP, READ, WAIT2, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       slot;
   logic             pend;
   logic [CNT_W-1:0] cnt;
   logic [15:0]      cmd_r;
   logic [11:0]      res [4];
   logic             err_r;
   logic             in_wait;
   logic             timeout;
   logic             unused_ok;

   // Slot-to-channel map folded into the SPI command word.
   function automatic logic [15:0] cmd_of(input logic [1:0] s);
      logic [2:0] chan;
      case (s)
         2'd0:    chan = 3'd0;
         2'd1:    chan = 3'd4;
         2'd2:    chan = 3'd5;
         default: chan = 3'd6;
      endcase
      return {2'b00, chan, 11'h000};
   endfunction

   assign in_wait = (state == WAIT1) || (state == WAIT2);
   // done wins over an expiring counter in the same cycle.
   assign timeout = in_wait && !bus.done && (cnt == TIMEOUT_C);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.nxt || pend) state_nxt = CMD;
         CMD:     state_nxt = WAIT1;
         WAIT1: begin
            if (bus.done)    state_nxt = GAP;
            else if (timeout) state_nxt = IDLE;
         end
         GAP:     if (cnt == GAP_LAST) state_nxt = READ;
         READ:    state_nxt = WAIT2;
         WAIT2: begin
            if (bus.done)    state_nxt = DONE;
            else if (timeout) state_nxt = IDLE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.wrt   = (state == CMD) || (state == READ);
      bus.vld   = (state == DONE);
      bus.busy  = (state != IDLE);
      bus.ch_id = slot;
   end

   // Slot, pending request, counter, command and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         slot  <= 2'd0;
         pend  <= 1'b0;
         cnt   <= '0;
         cmd_r <= 16'h0000;
         err_r <= 1'b0;
         for (int i = 0; i < 4; i++) res[i] <= 12'h000;
      end else begin
         // Leaving IDLE consumes the pending request; any number of
         // requests while busy collapse into a single pending one.
         if (state == IDLE)  pend <= 1'b0;
         else if (bus.nxt)   pend <= 1'b1;

         // Counter restarts on every state entry; only GAP and the waits use it.
         if (state_nxt != state)              cnt <= '0;
         else if (in_wait || (state == GAP))  cnt <= cnt + 1'b1;

         // cmd is loaded once per conversion and held for both transactions.
         if ((state == IDLE) && (state_nxt == CMD)) cmd_r <= cmd_of(slot);

         if ((state == WAIT2) && bus.done) res[slot] <= bus.rd_data[11:0];

         if (timeout) err_r <= 1'b1;

         if ((state == DONE) || timeout) slot <= slot + 1'b1;
      end
   end

   assign bus.cmd       = cmd_r;
   assign bus.lft_ld    = res[0];
   assign bus.rght_ld   = res[1];
   assign bus.steer_pot = res[2];
   assign bus.batt      = res[3];
   assign bus.err       = err_r;

   // Upper bits of the received word carry no conversion data.
   assign unused_ok = &{1'b0, bus.rd_data[15:12]};

endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 SHALL provide parameter GAP_CYCLES, default 4: idle cycles between the command and read SPI transactions.
REQ-002 SHALL provide parameter TIMEOUT, default 1023: maximum wait cycles for done before abort.
REQ-003 SHALL have port clk  in  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port nxt  in  1  single-cycle request to start one conversion (driven by inertial vld).
REQ-006 SHALL have port wrt  out  1  single-cycle strobe starting one SPI master transaction.
REQ-007 SHALL have port cmd  out  16  SPI command word, valid on wrt.
REQ-008 SHALL have port done  in  1  SPI master transaction complete, one cycle.
REQ-009 SHALL have port rd_data  in  16  SPI master received word, valid on done.
REQ-010 SHALL have port lft_ld  out  12  last left load-cell result.
REQ-011 SHALL have port rght_ld  out  12  last right load-cell result.
REQ-012 SHALL have port steer_pot  out  12  last steer-pot result.
REQ-013 SHALL have port batt  out  12  last battery result.
REQ-014 SHALL have port vld  out  1  one-cycle pulse when a result register updates.
REQ-015 SHALL have port ch_id  out  2  slot of the result flagged by vld.
REQ-016 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-017 SHALL have port err  out  1  sticky flag set by any timeout.

Function
REQ-018 SHALL map round-robin slots to ADC channels as follows: slot0 = ch0 (lft_ld), slot1 = ch4 (rght_ld), slot2 = ch5 (steer_pot), slot3 = ch6 (batt).
REQ-019 SHALL form cmd as {2'b00, chan[2:0], 11'h000} for both transactions of a conversion.
REQ-020 SHALL implement states IDLE, CMD, WAIT1, GAP, READ, WAIT2, DONE.
REQ-021 SHALL transition IDLE -> CMD on the first cycle in which nxt or pend is high, and clear pend on that transition.
REQ-022 SHALL, in CMD, assert wrt for exactly one cycle with cmd valid, then go to WAIT1.
REQ-023 SHALL, in WAIT1, go to GAP on done.
REQ-024 SHALL hold GAP for exactly GAP_CYCLES cycles, then go to READ.
REQ-025 SHALL, in READ, assert wrt for one cycle, then go to WAIT2.
REQ-026 SHALL, in WAIT2, go to DONE on done and capture rd_data[11:0] into the current slot's result register.
REQ-027 SHALL, in DONE, pulse vld for one cycle with ch_id = slot, advance slot modulo 4 (3 wraps to 0), and return to IDLE.
REQ-028 SHALL produce wrt in the cycle after nxt is sampled in IDLE, and vld in the cycle after the second done.
REQ-029 SHALL set pend when nxt arrives while busy; multiple nxt pulses collapse into one pending request.
REQ-030 SHALL run a wait counter in WAIT1 and WAIT2 that clears on entering each state.
REQ-031 SHALL, when the wait counter reaches TIMEOUT without done: set err, skip vld, leave result registers unchanged, advance slot, and go to IDLE.
REQ-032 SHALL give done priority over timeout when both occur in the same cycle.
REQ-033 SHALL ignore done in IDLE, CMD, GAP, READ and DONE.
REQ-034 SHALL hold cmd at its last value when wrt is low.
REQ-035 SHALL size the wait counter at 10 bits minimum, large enough for TIMEOUT without wrap.

Reset
REQ-036 SHALL, on rst high at a clock edge, force the state to IDLE and zero all of: slot, pend, counters, wrt, cmd, lft_ld, rght_ld, steer_pot, batt, vld, ch_id, busy and err.
REQ-037 SHALL let rst asserted mid-conversion abort the conversion with no vld pulse and no result update; the next conversion starts at slot0.
REQ-038 SHALL give rst priority over every other input, including done and nxt, in the same cycle.

Verification
REQ-039 SHALL cover a single conversion: nxt, done responds after 40 cycles with rd_data = 16'h0ABC -> cmd = 16'h0000 twice, wrt pulses separated by a gap of at least 4 cycles, lft_ld = 12'hABC, vld with ch_id = 0.
REQ-040 SHALL cover wrap-around: 5 conversions -> cmd sequence 0000, 2000, 2800, 3000, 0000, and the fifth result lands in lft_ld.
REQ-041 SHALL cover pending collapse: 3 nxt pulses during one conversion -> exactly one further conversion, then IDLE with busy = 0.
REQ-042 SHALL cover timeout: done withheld in WAIT2 -> err = 1 after 1023 cycles, no vld, rght_ld unchanged, next nxt uses slot2 (cmd 2800).
REQ-043 SHALL cover done coincident with timeout: done on the TIMEOUT cycle -> result captured, vld = 1, err = 0.
REQ-044 SHALL cover reset mid-operation: rst in GAP -> all outputs 0 next cycle, and the following nxt issues cmd 0000.
